// File: rtl/decode_unit_pkg.sv
// Shared pipeline-stage types: fetch/decode/execute registers, decoded op enum and opcode map.
package pipeline_stage_registers;

  localparam int REG_AW = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_LUI    = 4'd1,
    OP_AUIPC  = 4'd2,
    OP_JAL    = 4'd3,
    OP_JALR   = 4'd4,
    OP_BRANCH = 4'd5,
    OP_LOAD   = 4'd6,
    OP_STORE  = 4'd7,
    OP_OPIMM  = 4'd8,
    OP_OP     = 4'd9
  } op_e;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] fetched_inst;
    logic        do_not_execute;
  } IF_ID;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    op_e         op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        do_not_execute;
  } ID_EX;

endpackage

// File: rtl/decode_unit_regfile.sv
// 32-entry integer register file: two combinational read ports with writeback bypass, one write port.
module regfile
  import pipeline_stage_registers::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i
);

  logic [XLEN-1:0] regs_q [32];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_en_i && (wb_rd_i != '0)) begin
      regs_q[wb_rd_i] <= wb_data_i;
    end
  end

  // Bypass lets a same-cycle writeback reach the decoding instruction.
  always_comb begin
    rs1_data_o = regs_q[rs1_addr_i];
    if (rs1_addr_i == '0)                            rs1_data_o = '0;
    else if (wb_en_i && (wb_rd_i == rs1_addr_i))     rs1_data_o = wb_data_i;
    rs2_data_o = regs_q[rs2_addr_i];
    if (rs2_addr_i == '0)                            rs2_data_o = '0;
    else if (wb_en_i && (wb_rd_i == rs2_addr_i))     rs2_data_o = wb_data_i;
  end

endmodule

// File: rtl/decode_unit.sv
// Instruction decode stage: field/immediate extraction, control bits, early JAL redirect, ID/EX register.
module decode_unit
  import pipeline_stage_registers::*;
#(
  parameter int XLEN = 32,
  parameter int PCW  = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  IF_ID            if_id_r,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            jump_taken,
  output logic [PCW-1:0]  jump_target,
  output logic            illegal_inst,
  output ID_EX            id_ex_r
);

  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            legal;
  logic            rw_raw;
  logic            illegal_d, illegal_q;
  ID_EX            id_ex_d, id_ex_q;

  assign inst   = if_id_r.fetched_inst;
  assign opcode = inst[6:0];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  regfile #(.XLEN(XLEN)) u_regfile (
    .clk        (clk),
    .reset_n    (reset_n),
    .rs1_addr_i (inst[19:15]),
    .rs2_addr_i (inst[24:20]),
    .rs1_data_o (rs1_val),
    .rs2_data_o (rs2_val),
    .wb_en_i    (wb_en),
    .wb_rd_i    (wb_rd),
    .wb_data_i  (wb_data)
  );

  // JAL redirects from decode; JALR and branches wait for execute.
  assign jump_taken  = reset_n && !if_id_r.do_not_execute && (opcode == OPC_JAL);
  assign jump_target = if_id_r.pc + imm_j[PCW-1:0];

  always_comb begin
    id_ex_d          = '0;
    id_ex_d.pc       = if_id_r.pc;
    id_ex_d.rs1_val  = rs1_val;
    id_ex_d.rs2_val  = rs2_val;
    id_ex_d.rd       = inst[11:7];
    id_ex_d.funct3   = inst[14:12];
    id_ex_d.funct7b5 = inst[30];
    id_ex_d.op       = OP_NOP;
    legal            = 1'b1;
    rw_raw           = 1'b0;
    case (opcode)
      OPC_LUI:    begin id_ex_d.op = OP_LUI;    id_ex_d.imm = imm_u; rw_raw = 1'b1; end
      OPC_AUIPC:  begin id_ex_d.op = OP_AUIPC;  id_ex_d.imm = imm_u; rw_raw = 1'b1; end
      OPC_JAL:    begin id_ex_d.op = OP_JAL;    id_ex_d.imm = imm_j; rw_raw = 1'b1; end
      OPC_JALR:   begin id_ex_d.op = OP_JALR;   id_ex_d.imm = imm_i; rw_raw = 1'b1; end
      OPC_BRANCH: begin id_ex_d.op = OP_BRANCH; id_ex_d.imm = imm_b; end
      OPC_LOAD:   begin id_ex_d.op = OP_LOAD;   id_ex_d.imm = imm_i; rw_raw = 1'b1;
                        id_ex_d.mem_read = 1'b1; end
      OPC_STORE:  begin id_ex_d.op = OP_STORE;  id_ex_d.imm = imm_s;
                        id_ex_d.mem_write = 1'b1; end
      OPC_OPIMM:  begin id_ex_d.op = OP_OPIMM;  id_ex_d.imm = imm_i; rw_raw = 1'b1; end
      OPC_OP:     begin id_ex_d.op = OP_OP;     rw_raw = 1'b1; end
      default:    legal = 1'b0;
    endcase
    id_ex_d.reg_write = rw_raw && (inst[11:7] != 5'd0);
    if (if_id_r.do_not_execute || !legal) begin
      id_ex_d.op             = OP_NOP;
      id_ex_d.do_not_execute = 1'b1;
      id_ex_d.reg_write      = 1'b0;
      id_ex_d.mem_read       = 1'b0;
      id_ex_d.mem_write      = 1'b0;
    end
    illegal_d = !if_id_r.do_not_execute && !legal;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_ex_q                <= '0;
      id_ex_q.op             <= OP_NOP;
      id_ex_q.do_not_execute <= 1'b1;
      illegal_q              <= 1'b0;
    end else begin
      id_ex_q   <= id_ex_d;
      illegal_q <= illegal_d;
    end
  end

  assign id_ex_r      = id_ex_q;
  assign illegal_inst = illegal_q;

endmodule

// File: tb/tb_decode_unit.sv
// Directed table-driven bench for decode_unit plus hand sequences for reset and illegal-opcode timing.
module tb_decode_unit;
  import pipeline_stage_registers::*;

  logic        clk = 1'b0;
  logic        reset_n;
  IF_ID        if_id_r;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        jump_taken;
  logic [15:0] jump_target;
  logic        illegal_inst;
  ID_EX        id_ex_r;

  int n_cmp = 0;
  int n_err = 0;

  decode_unit #(.XLEN(32), .PCW(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .if_id_r      (if_id_r),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .jump_taken   (jump_taken),
    .jump_target  (jump_target),
    .illegal_inst (illegal_inst),
    .id_ex_r      (id_ex_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] inst;
    logic        dne;
    logic        wen;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic        jt;
    logic [15:0] jtgt;
    op_e         op;
    logic        chk_rs;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        chk_imm;
    logic [31:0] imm;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        dne_o;
    logic        ill;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".pc"},      32'(id_ex_r.pc), 32'h0);
    chk({tag, ".rs1"},     id_ex_r.rs1_val, 32'h0);
    chk({tag, ".rs2"},     id_ex_r.rs2_val, 32'h0);
    chk({tag, ".imm"},     id_ex_r.imm, 32'h0);
    chk({tag, ".rd"},      32'(id_ex_r.rd), 32'h0);
    chk({tag, ".op"},      32'(id_ex_r.op), 32'(OP_NOP));
    chk({tag, ".ctl"},     32'({id_ex_r.funct3, id_ex_r.funct7b5, id_ex_r.reg_write,
                                id_ex_r.mem_read, id_ex_r.mem_write}), 32'h0);
    chk({tag, ".dne"},     32'(id_ex_r.do_not_execute), 32'h1);
    chk({tag, ".illegal"}, 32'(illegal_inst), 32'h0);
    chk({tag, ".jt"},      32'(jump_taken), 32'h0);
  endtask

  task automatic apply(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    if_id_r.pc             = v.pc;
    if_id_r.fetched_inst   = v.inst;
    if_id_r.do_not_execute = v.dne;
    wb_en   = v.wen;
    wb_rd   = v.wrd;
    wb_data = v.wdat;
    #1;
    chk({t, ".jump_taken"}, 32'(jump_taken), 32'(v.jt));
    if (v.jt) chk({t, ".jump_target"}, 32'(jump_target), 32'(v.jtgt));
    @(posedge clk);
    #1;
    chk({t, ".pc"},        32'(id_ex_r.pc), 32'(v.pc));
    chk({t, ".op"},        32'(id_ex_r.op), 32'(v.op));
    chk({t, ".reg_write"}, 32'(id_ex_r.reg_write), 32'(v.rw));
    chk({t, ".mem_read"},  32'(id_ex_r.mem_read), 32'(v.mr));
    chk({t, ".mem_write"}, 32'(id_ex_r.mem_write), 32'(v.mw));
    chk({t, ".dne"},       32'(id_ex_r.do_not_execute), 32'(v.dne_o));
    chk({t, ".illegal"},   32'(illegal_inst), 32'(v.ill));
    if (v.chk_rs) begin
      chk({t, ".rs1_val"}, id_ex_r.rs1_val, v.rs1);
      chk({t, ".rs2_val"}, id_ex_r.rs2_val, v.rs2);
    end
    if (v.chk_imm) chk({t, ".imm"}, id_ex_r.imm, v.imm);
  endtask

  initial begin
    //          pc        inst          dne   wen   wrd   wdat          jt    jtgt        op         chk   rs1           rs2           chk   imm           rw    mr    mw    dneo  ill
    vecs[0]  = '{16'h0010, 32'h0080006F, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 16'h0018, OP_JAL,    1'b1, 32'h0,        32'h0,        1'b1, 32'h8,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'h0004, 32'hFF1FF06F, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 16'hFFF4, OP_JAL,    1'b1, 32'h0,        32'h0,        1'b1, 32'hFFFFFFF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'h0008, 32'h005280B3, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 16'h0000, OP_OP,     1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'h000C, 32'h00128193, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 16'h0000, OP_OPIMM,  1'b1, 32'hDEADBEEF, 32'h0,        1'b1, 32'h1,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'h0010, 32'h00000113, 1'b0, 1'b1, 5'd0, 32'h1234,     1'b0, 16'h0000, OP_OPIMM,  1'b1, 32'h0,        32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{16'h0014, 32'h00000113, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 16'h0000, OP_OPIMM,  1'b1, 32'h0,        32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'h0040, 32'h00000000, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 16'h0000, OP_NOP,    1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{16'h0020, 32'h0080006F, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 16'h0000, OP_NOP,    1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{16'h0044, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 16'h0000, OP_NOP,    1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{16'h0048, 32'hFFC2A303, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 16'h0000, OP_LOAD,   1'b1, 32'hDEADBEEF, 32'h0,        1'b1, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'h004C, 32'hFE50AC23, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 16'h0000, OP_STORE,  1'b1, 32'h0,        32'hDEADBEEF, 1'b1, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{16'h0050, 32'hFE000EE3, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 16'h0000, OP_BRANCH, 1'b1, 32'h0,        32'h0,        1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{16'h0054, 32'h123453B7, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 16'h0000, OP_LUI,    1'b1, 32'h0,        32'h0,        1'b1, 32'h12345000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{16'h0058, 32'h000280E7, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 16'h0000, OP_JALR,   1'b1, 32'hDEADBEEF, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{16'h005C, 32'h00001017, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 16'h0000, OP_AUIPC,  1'b1, 32'h0,        32'h0,        1'b1, 32'h00001000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset with a live JAL presented: redirect must stay quiet.
    reset_n                = 1'b0;
    if_id_r.pc             = 16'h0010;
    if_id_r.fetched_inst   = 32'h0080006F;
    if_id_r.do_not_execute = 1'b0;
    wb_en   = 1'b0;
    wb_rd   = 5'd0;
    wb_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) apply(vecs[i], i);

    // Mid-stream reset: illegal flag and in-flight decode are dropped, regfile cleared.
    @(negedge clk);
    if_id_r.pc             = 16'h0060;
    if_id_r.fetched_inst   = 32'hFFFFFFFF;
    if_id_r.do_not_execute = 1'b0;
    wb_en = 1'b0;
    @(posedge clk);
    #1;
    chk("mid.illegal_before", 32'(illegal_inst), 32'h1);
    #2;
    reset_n              = 1'b0;
    if_id_r.fetched_inst = 32'h0080006F;
    #1;
    chk_reset_state("mid");
    @(negedge clk);
    reset_n                = 1'b1;
    if_id_r.pc             = 16'h0100;
    if_id_r.fetched_inst   = 32'h00128193;
    if_id_r.do_not_execute = 1'b0;
    @(posedge clk);
    #1;
    chk("post.pc",      32'(id_ex_r.pc), 32'h0100);
    chk("post.op",      32'(id_ex_r.op), 32'(OP_OPIMM));
    chk("post.rs1_val", id_ex_r.rs1_val, 32'h0);
    chk("post.imm",     id_ex_r.imm, 32'h1);
    chk("post.illegal", 32'(illegal_inst), 32'h0);
    chk("post.dne",     32'(id_ex_r.do_not_execute), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_unit.md
DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  XLEN  32  register and datapath width.
  PCW  16  program counter width.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
  clk  in  1  clock; reset reset_n, asynchronous, active-low.
  reset_n  in  1  asynchronous active-low reset.
  if_id_r  in  IF_ID  fetch output: pc[15:0], fetched_inst[31:0], do_not_execute.
  wb_en  in  1  register-file write enable from writeback.
  wb_rd  in  5  writeback destination register.
  wb_data  in  32  writeback data.
  jump_taken  out  1  combinational redirect request to PC logic.
  jump_target  out  16  combinational redirect address.
  illegal_inst  out  1  registered one-cycle flag for an undecodable opcode.
  id_ex_r  out  ID_EX  decode/execute pipeline register.

Function
REQ-003 id_ex_r SHALL update every clock edge from the current if_id_r, giving exactly one cycle of latency; there is no stall input.
REQ-004 ID_EX SHALL carry these fields:
  - pc[15:0], rs1_val[31:0], rs2_val[31:0], imm[31:0], rd[4:0];
  - op (enum: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, NOP);
  - funct3[2:0], funct7b5, reg_write, mem_read, mem_write, do_not_execute.
REQ-005 Recognised opcodes [6:0] SHALL be:
  - 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH;
  - 0000011 LOAD, 0100011 STORE, 0010011 OPIMM, 0110011 OP.
REQ-006 Immediates SHALL be sign-extended from bit 31 to 32 bits.
  - I: JALR, LOAD, OPIMM. S: STORE. B: BRANCH, bit 0 = 0.
  - U: LUI, AUIPC, low 12 bits zero. J: JAL, bit 0 = 0.
REQ-007 Control bits SHALL be set as follows:
  - reg_write = 1 for LUI, AUIPC, JAL, JALR, LOAD, OPIMM and OP, and forced to 0 when rd = 0.
  - mem_read = 1 for LOAD only.
  - mem_write = 1 for STORE only.
REQ-008 When if_id_r.do_not_execute = 1, the block SHALL set the following in id_ex_r and SHALL keep pc unchanged:
  - op = NOP, do_not_execute = 1;
  - reg_write = 0, mem_read = 0, mem_write = 0.
REQ-009 An unrecognised opcode with do_not_execute = 0 SHALL produce the bubble of REQ-008 and SHALL assert illegal_inst for exactly the following cycle.
REQ-010 jump_taken SHALL be 1 when if_id_r holds a JAL with do_not_execute = 0, and 0 otherwise.
REQ-011 jump_target SHALL be the low 16 bits of (if_id_r.pc + J-immediate), wrapping modulo 2^16; it is undefined-but-stable when jump_taken = 0.
REQ-012 JALR and BRANCH SHALL NOT assert jump_taken; the execute stage resolves them.
REQ-013 Register file: 32 x 32 bits.
  - x0 reads 0 and ignores writes.
  - Writes occur at the clock edge when wb_en = 1.
REQ-014 Reads SHALL be combinational with write-through bypass.
  - A source register equal to a nonzero wb_rd with wb_en = 1 reads wb_data in that same cycle.
REQ-015 Simultaneous writeback and decode of the same register SHALL yield the new value in id_ex_r.rs1_val and id_ex_r.rs2_val.

Reset
REQ-016 During reset_n = 0, the block SHALL set the following:
  - id_ex_r: all fields 0 except op = NOP and do_not_execute = 1;
  - illegal_inst = 0;
  - all register-file entries 0.
REQ-017 jump_taken SHALL be 0 while reset_n = 0, regardless of if_id_r.
REQ-018 Reset asserted mid-operation SHALL discard the in-flight instruction; the first edge after release decodes the current if_id_r.

Structure
REQ-019 The IF_ID struct, the ID_EX struct, the op enum and the opcode localparams SHALL live in the shared pipeline_stage_registers package.
REQ-020 The register file SHALL be a separate sub-module, regfile, with two combinational read ports, one write port and the bypass logic.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
  - if_id_r = {pc 0x0010, inst 0x0080006F} (JAL x0, +8) -> jump_taken = 1, jump_target = 0x0018; next cycle id_ex_r.op = JAL, reg_write = 0, imm = 8.
  - JAL -16 at pc 0x0004 -> jump_target = 0xFFF4 (wrap).
  - wb_en = 1, wb_rd = 5, wb_data = 0xDEADBEEF in the same cycle as decoding ADD x1, x5, x5 (0x005280B3) -> rs1_val = rs2_val = 0xDEADBEEF, reg_write = 1.
  - wb_en = 1, wb_rd = 0, wb_data = 0x1234, then decode ADDI x2, x0, 0 -> rs1_val = 0.
  - do_not_execute = 1 with inst 0x00000000 -> op = NOP, all write enables 0, illegal_inst = 0, jump_taken = 0.
  - inst 0xFFFFFFFF, do_not_execute = 0 -> illegal_inst high exactly one cycle, bubble issued.
  - reset_n pulsed low mid-stream -> outputs match REQ-016 immediately, and REQ-017 holds.
